nn_param_streamer: RTL and testbench

NN_PARAM_STREAMER -- requirements
Module: nn_param_streamer

---
 rtl/nn_param_streamer_if.sv | 38 +++
 rtl/nn_param_streamer.sv | 158 +++++++++++++++
 tb/tb_nn_param_streamer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nn_param_streamer_if.sv
// Parameter-load and beat-stream bundle for nn_param_streamer.
// slave: the streamer itself; master: host loading weights and consuming beats.
interface nn_param_streamer_if #(
    parameter int DATA_W = 16,
    parameter int NA     = 3,
    parameter int IA     = 3
);
    logic              wr_en;
    logic              wr_bias;
    logic [NA-1:0]     wr_n;
    logic [IA-1:0]     wr_i;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              req;
    logic [NA-1:0]     req_n;
    logic              busy;
    logic              req_err;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IA-1:0]     out_idx;
    logic              out_is_bias;
    logic              out_last;

    modport slave (
        input  wr_en, wr_bias, wr_n, wr_i, wr_data,
        input  req, req_n, out_ready,
        output wr_err, busy, req_err,
        output out_valid, out_data, out_idx, out_is_bias, out_last
    );

    modport master (
        output wr_en, wr_bias, wr_n, wr_i, wr_data,
        output req, req_n, out_ready,
        input  wr_err, busy, req_err,
        input  out_valid, out_data, out_idx, out_is_bias, out_last
    );
endinterface

// File: rtl/nn_param_streamer.sv
// Stores per-neuron weights and bias; streams N_INPUTS weights then bias.
// Ports: clk, rst_n (async low), bus (nn_param_streamer_if.slave).
module nn_param_streamer #(
    parameter int DATA_W    = 16,
    parameter int N_NEURONS = 8,
    parameter int N_INPUTS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    nn_param_streamer_if.slave bus
);
    localparam int NA = $clog2(N_NEURONS);
    localparam int IA = $clog2(N_INPUTS + 1);
    localparam int NW = N_NEURONS * N_INPUTS;
    localparam int AW = $clog2(NW);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WEIGHT = 2'd1;
    localparam logic [1:0] S_BIAS   = 2'd2;

    logic [DATA_W-1:0] weight_q [NW];
    logic [DATA_W-1:0] bias_q   [N_NEURONS];

    logic [1:0]        state_q, state_d;
    logic [NA-1:0]     n_q, n_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IA-1:0]     out_idx_q, out_idx_d;
    logic              out_is_bias_q, out_is_bias_d;
    logic              wr_err_q, wr_err_d;
    logic              req_err_q, req_err_d;

    logic              busy;
    logic              wr_ok;
    logic              req_in_range;
    logic              xfer;
    logic [AW-1:0]     wr_addr;
    logic [NA-1:0]     rd_n;
    logic [31:0]       rd_i;
    logic [31:0]       rd_lin;
    logic [DATA_W-1:0] rd_word;

    assign busy = (state_q != S_IDLE);
    assign xfer = out_valid_q && bus.out_ready;

    assign req_in_range = (32'(bus.req_n) < N_NEURONS);

    assign wr_ok = bus.wr_en && !busy
                && (32'(bus.wr_n) < N_NEURONS)
                && (bus.wr_bias || (32'(bus.wr_i) < N_INPUTS));

    assign wr_addr = AW'(32'(bus.wr_n) * N_INPUTS + 32'(bus.wr_i));

    // Storage is deliberately not reset: contents survive a stream abort.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.wr_bias) begin
                bias_q[bus.wr_n] <= bus.wr_data;
            end else begin
                weight_q[wr_addr] <= bus.wr_data;
            end
        end
    end

    // Next weight to present: first weight of req_n when starting,
    // otherwise the one after the current beat of the latched neuron.
    always_comb begin
        rd_n = n_q;
        rd_i = 32'(out_idx_q) + 32'd1;
        if (state_q == S_IDLE) begin
            rd_n = bus.req_n;
            rd_i = 32'd0;
        end
        rd_lin = 32'(rd_n) * N_INPUTS + rd_i;
        rd_word = '0;
        if (rd_lin < NW) begin
            rd_word = weight_q[AW'(rd_lin)];
        end
    end

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_idx_d     = out_idx_q;
        out_is_bias_d = out_is_bias_q;
        wr_err_d      = bus.wr_en && !wr_ok;
        req_err_d     = bus.req && (busy || !req_in_range);
        unique case (state_q)
            S_IDLE: begin
                if (bus.req && req_in_range) begin
                    state_d       = S_WEIGHT;
                    n_d           = bus.req_n;
                    out_valid_d   = 1'b1;
                    out_data_d    = rd_word;
                    out_idx_d     = '0;
                    out_is_bias_d = 1'b0;
                end
            end
            S_WEIGHT: begin
                if (xfer) begin
                    if (out_idx_q == IA'(N_INPUTS - 1)) begin
                        state_d       = S_BIAS;
                        out_data_d    = bias_q[n_q];
                        out_idx_d     = IA'(N_INPUTS);
                        out_is_bias_d = 1'b1;
                    end else begin
                        out_data_d = rd_word;
                        out_idx_d  = out_idx_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (xfer) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b0;
                    out_is_bias_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            out_is_bias_q <= 1'b0;
            wr_err_q      <= 1'b0;
            req_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_idx_q     <= out_idx_d;
            out_is_bias_q <= out_is_bias_d;
            wr_err_q      <= wr_err_d;
            req_err_q     <= req_err_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.wr_err      = wr_err_q;
    assign bus.req_err     = req_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.out_is_bias = out_is_bias_q;
    assign bus.out_last    = out_is_bias_q;
endmodule

// File: tb/tb_nn_param_streamer.sv
// Randomized bench for nn_param_streamer against an array-based model.
// Uses the 10-neuron, 9-input, 24-bit configuration.
module tb_nn_param_streamer;
    localparam int DW = 24;
    localparam int NN = 10;
    localparam int NI = 9;
    localparam int NA = 4;
    localparam int IA = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    nn_param_streamer_if #(.DATA_W(DW), .NA(NA), .IA(IA)) bus ();

    nn_param_streamer #(
        .DATA_W(DW), .N_NEURONS(NN), .N_INPUTS(NI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] wm [NN][NI];
    logic [DW-1:0] bm [NN];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int b, input int n, input int i,
                            input logic [DW-1:0] d);
        bit ok;
        ok = (n < NN) && (b != 0 || i < NI);
        bus.wr_en   = 1'b1;
        bus.wr_bias = (b != 0);
        bus.wr_n    = NA'(n);
        bus.wr_i    = IA'(i);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        chk("wr_err", 32'(bus.wr_err), 32'(!ok));
        if (ok) begin
            if (b != 0) bm[n] = d;
            else wm[n][i] = d;
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall on beat 2
    task automatic run_stream(input int n, input int mode, input bit inj);
        int k = 0;
        int stall = 0;
        bit done_inj = 0;
        bit rdy;
        logic [DW-1:0] exp_d;
        bus.req   = 1'b1;
        bus.req_n = NA'(n);
        tick();
        bus.req = 1'b0;
        for (int cyc = 0; cyc < 200 && k <= NI; cyc++) begin
            exp_d = (k < NI) ? wm[n][k] : bm[n];
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("busy", 32'(bus.busy), 32'd1);
            chk("data", 32'(bus.out_data), 32'(exp_d));
            chk("idx", 32'(bus.out_idx), 32'(k));
            chk("is_bias", 32'(bus.out_is_bias), 32'(k == NI));
            chk("last", 32'(bus.out_last), 32'(k == NI));
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom % 3) != 0;
                default: rdy = !(k == 2 && stall < 3);
            endcase
            if (!rdy) stall++;
            bus.out_ready = rdy;
            bus.req_n = NA'($urandom % 16);
            if (inj && k == 2 && !done_inj) begin
                done_inj    = 1;
                bus.req     = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_bias = 1'($urandom);
                bus.wr_n    = NA'($urandom % NN);
                bus.wr_i    = IA'($urandom % NI);
                bus.wr_data = DW'($urandom);
                tick();
                bus.req   = 1'b0;
                bus.wr_en = 1'b0;
                chk("busy_req_err", 32'(bus.req_err), 32'd1);
                chk("busy_wr_err", 32'(bus.wr_err), 32'd1);
            end else begin
                tick();
            end
            if (rdy) k++;
        end
        bus.out_ready = 1'b0;
        chk("stream_len", 32'(k), 32'(NI + 1));
        chk("end_valid", 32'(bus.out_valid), 32'd0);
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_last", 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_bias = 0; bus.wr_n = '0; bus.wr_i = '0;
        bus.wr_data = '0; bus.req = 0; bus.req_n = '0; bus.out_ready = 0;
        #3;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_bias", 32'(bus.out_is_bias), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wr_err", 32'(bus.wr_err), 32'd0);
        chk("rst_req_err", 32'(bus.req_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) do_write(0, n, i, DW'((n << 16) | (i << 8) | 8'h5A));
            do_write(1, n, 0, DW'(24'hB00000 | n));
        end
        for (int i = 0; i < NI; i++) do_write(0, 3, i, DW'(8'h11 * (i + 1)));
        do_write(1, 3, 0, 24'h000F00);
        run_stream(3, 0, 0);
        run_stream(3, 2, 0);
        for (int n = 0; n < NN; n++) run_stream(n, 1, 0);

        for (int i = NI; i < 16; i++) do_write(0, 3, i, 24'hDEAD00);
        do_write(1, 12, 0, 24'hDEAD01);
        do_write(0, 15, 2, 24'hDEAD02);
        for (int n = NN; n < 16; n++) begin
            bus.req = 1'b1;
            bus.req_n = NA'(n);
            tick();
            bus.req = 1'b0;
            chk("oor_req_err", 32'(bus.req_err), 32'd1);
            chk("oor_valid", 32'(bus.out_valid), 32'd0);
            tick();
            chk("oor_req_err_pulse", 32'(bus.req_err), 32'd0);
        end
        run_stream(3, 0, 0);

        run_stream(5, 1, 1);
        run_stream(3, 0, 1);
        for (int t = 0; t < 40; t++)
            do_write(int'($urandom % 2), int'($urandom % 16),
                     int'($urandom % 16), DW'($urandom));
        for (int t = 0; t < 6; t++)
            run_stream(int'($urandom % NN), 1, 1'($urandom));

        bus.req = 1'b1;
        bus.req_n = 4'd3;
        tick();
        bus.req = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pre_rst_idx", 32'(bus.out_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_idx", 32'(bus.out_idx), 32'd0);
        chk("arst_bias", 32'(bus.out_is_bias), 32'd0);
        chk("arst_last", 32'(bus.out_last), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("arst_hold_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        run_stream(3, 0, 0);
        run_stream(7, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
